// File: rtl/nn_arb_pkg.sv
// Shared types and constants for the NN block bus arbiter.
package nn_arb_pkg;

  localparam logic RW_WRITE = 1'b1;
  localparam logic RW_READ  = 1'b0;

  localparam int unsigned NN_ARB_N_MASTERS = 2;

  typedef enum logic {ARB_IDLE, ARB_GRANT} arb_state_t;

  // Master ID for the default two-master build (host + DMA).
  typedef logic [$clog2(NN_ARB_N_MASTERS)-1:0] master_id_t;

endpackage

// File: rtl/nn_arb_id_fifo.sv
// Owner-ID FIFO: remembers which master issued each outstanding read, in issue order.
module nn_arb_id_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             push_ok, pop_ok;

  assign full_o  = (cnt_q == CntW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign head_o  = mem_q[rd_ptr_q];

  // Full rejects a push even if a pop happens in the same cycle.
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  // Pointer and occupancy next-state.
  always_comb begin
    wr_ptr_d = wr_ptr_q + PtrW'(push_ok);
    rd_ptr_d = rd_ptr_q + PtrW'(pop_ok);
    cnt_d    = cnt_q;
    case ({push_ok, pop_ok})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Pointer and occupancy state, synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage needs no reset: entries are only read after being written.
  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

endmodule

// File: rtl/nn_bus_arbiter.sv
// Round-robin arbiter sharing one NN block slave port between several bus masters,
// with bounded bursts and in-order routing of read responses back to their issuer.
module nn_bus_arbiter
  import nn_arb_pkg::*;
#(
  parameter int unsigned N_MASTERS = NN_ARB_N_MASTERS,
  parameter int unsigned OUTST     = 4,
  parameter int unsigned MAX_BURST = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [N_MASTERS-1:0]       m_sel,
  input  logic [N_MASTERS-1:0]       m_RW,
  input  logic [N_MASTERS-1:0][19:0] m_addr,
  input  logic [N_MASTERS-1:0][31:0] m_din,
  output logic [N_MASTERS-1:0][31:0] m_dout,
  output logic [N_MASTERS-1:0]       m_bus_stop,
  output logic [N_MASTERS-1:0]       m_pushout,
  output logic                       s_sel,
  output logic                       s_RW,
  output logic [19:0]                s_addr,
  output logic [31:0]                s_din,
  input  logic [31:0]                s_dout,
  input  logic                       s_bus_stop,
  input  logic                       s_pushout,
  output logic                       err_orphan
);

  localparam int unsigned IdW    = $clog2(N_MASTERS);
  localparam int unsigned BurstW = $clog2(MAX_BURST + 1);
  localparam logic [BurstW-1:0] BurstLast = BurstW'(MAX_BURST - 1);
  localparam logic [IdW-1:0]    LastId    = IdW'(N_MASTERS - 1);

  arb_state_t        state_q, state_d;
  logic [IdW-1:0]    owner_q, owner_d;
  logic [IdW-1:0]    rr_ptr_q, rr_ptr_d;
  logic [BurstW-1:0] burst_cnt_q, burst_cnt_d;
  logic              err_orphan_q;

  logic              granted;
  logic              rd_block;
  logic              accept;
  logic              found;
  logic [IdW-1:0]    pick;
  int unsigned       idx;

  logic              fifo_push, fifo_pop;
  logic              fifo_full, fifo_empty;
  logic [IdW-1:0]    fifo_head;

  assign granted  = (state_q == ARB_GRANT);
  // Reads stall while the owner FIFO is full; writes are never held back by it.
  assign rd_block = granted && (m_RW[owner_q] == RW_READ) && fifo_full;
  assign s_sel    = granted && m_sel[owner_q] && !rd_block;
  assign accept   = s_sel && !s_bus_stop;

  // Round-robin pick: first requester at or after rr_ptr, wrapping.
  always_comb begin
    found = 1'b0;
    pick  = rr_ptr_q;
    idx   = 0;
    for (int unsigned k = 0; k < N_MASTERS; k++) begin
      idx = (int'(rr_ptr_q) + k) % N_MASTERS;
      if (!found && m_sel[idx]) begin
        found = 1'b1;
        pick  = IdW'(idx);
      end
    end
  end

  // Slave-side request mux and per-master stall.
  always_comb begin
    s_RW       = 1'b0;
    s_addr     = '0;
    s_din      = '0;
    m_bus_stop = '1;
    if (granted) begin
      s_RW                = m_RW[owner_q];
      s_addr              = m_addr[owner_q];
      s_din               = m_din[owner_q];
      m_bus_stop[owner_q] = s_bus_stop || rd_block;
    end
  end

  // Arbitration FSM, round-robin pointer and burst counter next-state.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    rr_ptr_d    = rr_ptr_q;
    burst_cnt_d = burst_cnt_q;
    case (state_q)
      ARB_IDLE: begin
        if (found) begin
          state_d = ARB_GRANT;
          owner_d = pick;
        end
      end
      ARB_GRANT: begin
        if (accept) begin
          burst_cnt_d = burst_cnt_q + 1'b1;
        end
        if (!m_sel[owner_q] || (accept && (burst_cnt_q == BurstLast))) begin
          state_d     = ARB_IDLE;
          burst_cnt_d = '0;
          rr_ptr_d    = (owner_q == LastId) ? '0 : owner_q + 1'b1;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // Arbiter state, synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ARB_IDLE;
      owner_q      <= '0;
      rr_ptr_q     <= '0;
      burst_cnt_q  <= '0;
      err_orphan_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      rr_ptr_q     <= rr_ptr_d;
      burst_cnt_q  <= burst_cnt_d;
      if (s_pushout && fifo_empty) begin
        err_orphan_q <= 1'b1;
      end
    end
  end

  assign err_orphan = err_orphan_q;

  assign fifo_push = accept && (s_RW == RW_READ);
  assign fifo_pop  = s_pushout && !fifo_empty;

  nn_arb_id_fifo #(
    .DEPTH (OUTST),
    .WIDTH (IdW)
  ) u_id_fifo (
    .clk_i   (clk),
    .rst_i   (reset),
    .push_i  (fifo_push),
    .data_i  (owner_q),
    .pop_i   (fifo_pop),
    .head_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Zero-latency response routing to the master at the FIFO head.
  always_comb begin
    m_pushout = '0;
    m_dout    = '0;
    if (fifo_pop) begin
      m_pushout[fifo_head] = 1'b1;
      m_dout[fifo_head]    = s_dout;
    end
  end

endmodule

// File: tb/tb_nn_bus_arbiter.sv
// Scoreboard bench for nn_bus_arbiter: stimulus pushes expected slave transfers and
// read responses, a negedge monitor pops and compares them as the DUT presents them.
module tb_nn_bus_arbiter;

  localparam int N = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic [N-1:0]      m_sel;
  logic [N-1:0]      m_RW;
  logic [N-1:0][19:0] m_addr;
  logic [N-1:0][31:0] m_din;
  logic [N-1:0][31:0] m_dout;
  logic [N-1:0]      m_bus_stop;
  logic [N-1:0]      m_pushout;
  logic              s_sel;
  logic              s_RW;
  logic [19:0]       s_addr;
  logic [31:0]       s_din;
  logic [31:0]       s_dout;
  logic              s_bus_stop;
  logic              s_pushout;
  logic              err_orphan;

  typedef struct {
    logic        rw;
    logic [19:0] addr;
    logic [31:0] din;
  } xfer_t;

  typedef struct {
    int          master;
    logic [31:0] data;
  } resp_t;

  xfer_t exp_xfer[$];
  resp_t exp_resp[$];

  int n_checks = 0;
  int n_fail   = 0;

  nn_bus_arbiter #(
    .N_MASTERS (N),
    .OUTST     (4),
    .MAX_BURST (8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .m_sel      (m_sel),
    .m_RW       (m_RW),
    .m_addr     (m_addr),
    .m_din      (m_din),
    .m_dout     (m_dout),
    .m_bus_stop (m_bus_stop),
    .m_pushout  (m_pushout),
    .s_sel      (s_sel),
    .s_RW       (s_RW),
    .s_addr     (s_addr),
    .s_din      (s_din),
    .s_dout     (s_dout),
    .s_bus_stop (s_bus_stop),
    .s_pushout  (s_pushout),
    .err_orphan (err_orphan)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_x(input logic rw, input logic [19:0] addr, input logic [31:0] din);
    xfer_t x;
    x.rw   = rw;
    x.addr = addr;
    x.din  = din;
    exp_xfer.push_back(x);
  endtask

  task automatic push_r(input int master, input logic [31:0] data);
    resp_t r;
    r.master = master;
    r.data   = data;
    exp_resp.push_back(r);
  endtask

  task automatic do_reset();
    reset      = 1'b1;
    m_sel      = '0;
    m_RW       = '0;
    m_addr     = '0;
    m_din      = '0;
    s_dout     = '0;
    s_bus_stop = 1'b0;
    s_pushout  = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Monitor: every accepted transfer and every routed response is checked against the queues.
  always @(negedge clk) begin
    if (reset === 1'b0) begin
      if (s_sel && !s_bus_stop) begin
        if (exp_xfer.size() == 0) begin
          chk("unexpected_xfer", {12'b0, s_addr}, 32'hFFFF_FFFF);
        end else begin
          xfer_t x;
          x = exp_xfer.pop_front();
          chk("xfer_rw", 32'(s_RW), 32'(x.rw));
          chk("xfer_addr", {12'b0, s_addr}, {12'b0, x.addr});
          if (x.rw) chk("xfer_din", s_din, x.din);
        end
      end
      if (m_pushout != '0) begin
        if (exp_resp.size() == 0) begin
          chk("unexpected_pushout", 32'(m_pushout), 32'h0);
        end else begin
          resp_t r;
          r = exp_resp.pop_front();
          chk("resp_route", 32'(m_pushout), 32'(1) << r.master);
          chk("resp_data", m_dout[r.master], r.data);
          for (int j = 0; j < N; j++) begin
            if (j != r.master) chk("resp_other_dout", m_dout[j], 32'h0);
          end
        end
      end
    end
  end

  initial begin
    do_reset();

    // Reset values
    @(negedge clk);
    chk("rst_s_sel", 32'(s_sel), 32'h0);
    chk("rst_bus_stop", 32'(m_bus_stop), 32'h3);
    chk("rst_pushout", 32'(m_pushout), 32'h0);
    chk("rst_dout0", m_dout[0], 32'h0);
    chk("rst_dout1", m_dout[1], 32'h0);
    chk("rst_orphan", 32'(err_orphan), 32'h0);
    tick();

    // T1: single write, one-cycle arbitration latency
    do_reset();
    m_sel = 2'b01; m_RW = 2'b01; m_addr[0] = 20'h00010; m_din[0] = 32'h0000_1234;
    push_x(1'b1, 20'h00010, 32'h0000_1234);
    @(negedge clk);
    chk("t1_c0_sel", 32'(s_sel), 32'h0);
    chk("t1_c0_stop", 32'(m_bus_stop), 32'h3);
    tick();
    @(negedge clk);
    chk("t1_c1_sel", 32'(s_sel), 32'h1);
    chk("t1_c1_addr", {12'b0, s_addr}, 32'h10);
    chk("t1_c1_stop", 32'(m_bus_stop), 32'h2);
    tick();
    m_sel = 2'b00;
    @(negedge clk);
    chk("t1_c2_sel", 32'(s_sel), 32'h0);
    chk("t1_c2_stop1", 32'(m_bus_stop[1]), 32'h1);
    tick();

    // T2: both masters continuously, 8-transfer bursts with 1-cycle bubbles
    do_reset();
    m_sel = 2'b11; m_RW = 2'b11;
    m_addr[0] = 20'h00100; m_din[0] = 32'h0000_00A0;
    m_addr[1] = 20'h00200; m_din[1] = 32'h0000_00B1;
    for (int g = 0; g < 4; g++) begin
      for (int b = 0; b < 8; b++) begin
        if (g % 2 == 0) push_x(1'b1, 20'h00100, 32'h0000_00A0);
        else            push_x(1'b1, 20'h00200, 32'h0000_00B1);
      end
    end
    for (int c = 0; c < 36; c++) begin
      @(negedge clk);
      chk("t2_sel_pattern", 32'(s_sel), (c == 0) ? 32'h0 : ((((c - 1) % 9) < 8) ? 32'h1 : 32'h0));
      tick();
    end
    m_sel = 2'b00;
    @(negedge clk);
    chk("t2_end_sel", 32'(s_sel), 32'h0);
    tick();

    // T3: four reads fill the owner FIFO, fifth stalls until a response pops
    do_reset();
    m_sel = 2'b01; m_RW = 2'b00; m_addr[0] = 20'h00030;
    for (int i = 0; i < 5; i++) push_x(1'b0, 20'h00030, 32'h0);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("t3_fill_sel", 32'(s_sel), (c >= 1) ? 32'h1 : 32'h0);
      tick();
    end
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk("t3_full_sel", 32'(s_sel), 32'h0);
      chk("t3_full_stop", 32'(m_bus_stop[0]), 32'h1);
      tick();
    end
    s_pushout = 1'b1; s_dout = 32'hDEADBEEF;
    push_r(0, 32'hDEADBEEF);
    @(negedge clk);
    chk("t3_no_bypass", 32'(s_sel), 32'h0);
    tick();
    s_pushout = 1'b0;
    @(negedge clk);
    chk("t3_resume_sel", 32'(s_sel), 32'h1);
    chk("t3_resume_stop", 32'(m_bus_stop[0]), 32'h0);
    tick();
    m_sel = 2'b00;
    for (int i = 0; i < 4; i++) begin
      s_pushout = 1'b1; s_dout = 32'hC0 + 32'(i);
      push_r(0, 32'hC0 + 32'(i));
      tick();
    end
    s_pushout = 1'b0;
    @(negedge clk);
    chk("t3_no_orphan", 32'(err_orphan), 32'h0);
    tick();

    // T4: reads from m0 then m1, responses stay in issue order
    do_reset();
    m_sel = 2'b01; m_RW = 2'b00; m_addr[0] = 20'h00040; m_addr[1] = 20'h00050;
    push_x(1'b0, 20'h00040, 32'h0);
    tick();
    tick();
    m_sel = 2'b10;
    push_x(1'b0, 20'h00050, 32'h0);
    tick();
    tick();
    tick();
    m_sel = 2'b00;
    s_pushout = 1'b1; s_dout = 32'h11; push_r(0, 32'h11);
    tick();
    s_dout = 32'h22; push_r(1, 32'h22);
    tick();
    s_pushout = 1'b0;
    tick();

    // T5: slave stall freezes the burst; exactly 8 accepts afterwards
    do_reset();
    m_sel = 2'b01; m_RW = 2'b01; m_addr[0] = 20'h00060; m_din[0] = 32'h0000_5555;
    s_bus_stop = 1'b1;
    for (int i = 0; i < 8; i++) push_x(1'b1, 20'h00060, 32'h0000_5555);
    tick();
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      chk("t5_stall_sel", 32'(s_sel), 32'h1);
      chk("t5_stall_stop", 32'(m_bus_stop[0]), 32'h1);
      tick();
    end
    s_bus_stop = 1'b0;
    for (int c = 4; c <= 11; c++) begin
      @(negedge clk);
      chk("t5_run_stop", 32'(m_bus_stop[0]), 32'h0);
      tick();
    end
    @(negedge clk);
    chk("t5_burst_end_sel", 32'(s_sel), 32'h0);
    tick();
    m_sel = 2'b00;
    tick();
    tick();

    // T6: reset mid-burst with two reads outstanding; later responses are orphans
    do_reset();
    m_sel = 2'b01; m_RW = 2'b00; m_addr[0] = 20'h00070;
    push_x(1'b0, 20'h00070, 32'h0);
    push_x(1'b0, 20'h00070, 32'h0);
    tick();
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    m_sel = 2'b00;
    @(negedge clk);
    chk("t6_sel", 32'(s_sel), 32'h0);
    chk("t6_stop", 32'(m_bus_stop), 32'h3);
    chk("t6_pushout", 32'(m_pushout), 32'h0);
    chk("t6_dout0", m_dout[0], 32'h0);
    chk("t6_dout1", m_dout[1], 32'h0);
    chk("t6_orphan_clr", 32'(err_orphan), 32'h0);
    tick();
    for (int i = 0; i < 2; i++) begin
      s_pushout = 1'b1; s_dout = 32'h99;
      @(negedge clk);
      chk("t6_orphan_pushout", 32'(m_pushout), 32'h0);
      tick();
    end
    s_pushout = 1'b0;
    @(negedge clk);
    chk("t6_orphan_set", 32'(err_orphan), 32'h1);
    tick();

    chk("xfer_queue_drained", 32'(exp_xfer.size()), 32'h0);
    chk("resp_queue_drained", 32'(exp_resp.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
